// File: rtl/tap_ctl_resp_pkg.sv
// Shared definitions for the TAP control responder: control-word layout, field
// extractors and FSM state types.
package tap_ctl_resp_pkg;

    localparam int unsigned TapCtlSize   = 18;
    localparam int unsigned TapCtlGt     = 0;
    localparam int unsigned TapCtlEt     = 1;
    localparam int unsigned TapCtlLt     = 2;
    localparam int unsigned TapCtlThrLsb = 3;
    localparam int unsigned TapCtlThrMsb = 16;
    localparam int unsigned TapCtlTrigEn = 17;
    localparam int unsigned TapThrW      = TapCtlThrMsb - TapCtlThrLsb + 1;

    typedef logic [TapCtlSize-1:0] tap_ctl_t;

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StDac,
        StApply,
        StDone
    } resp_state_e;

    typedef enum logic [1:0] {
        SpiIdle,
        SpiSync,
        SpiShift,
        SpiTail
    } spi_state_e;

    function automatic logic [TapThrW-1:0] tap_ctl_thr(input tap_ctl_t c);
        return c[TapCtlThrMsb:TapCtlThrLsb];
    endfunction

    function automatic logic tap_ctl_gt(input tap_ctl_t c);
        return c[TapCtlGt];
    endfunction

    function automatic logic tap_ctl_et(input tap_ctl_t c);
        return c[TapCtlEt];
    endfunction

    function automatic logic tap_ctl_lt(input tap_ctl_t c);
        return c[TapCtlLt];
    endfunction

    function automatic logic tap_ctl_trig_en(input tap_ctl_t c);
        return c[TapCtlTrigEn];
    endfunction

endpackage

// File: rtl/tap_dac_spi.sv
// 3-wire SPI writer for the threshold DAC: sync lead-in, MSB-first shift with the DAC
// sampling on falling sclk, then a tail before sync is released.
module tap_dac_spi
    import tap_ctl_resp_pkg::*;
#(
    parameter int unsigned ClkDiv  = 4,
    parameter int unsigned DacBits = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [DacBits-1:0] data_i,
    output logic               done_o,
    output logic               sync_n_o,
    output logic               sclk_o,
    output logic               din_o
);

    localparam int unsigned BitW = $clog2(DacBits + 1);

    spi_state_e         state_q;
    logic [7:0]         div_q;
    logic [BitW-1:0]    bit_q;
    logic               phase_q;
    logic [DacBits-1:0] sh_q;
    logic               sync_n_q;
    logic               sclk_q;
    logic               last_div;
    logic               last_bit;

    assign last_div = (div_q == 8'(ClkDiv - 1));
    assign last_bit = (bit_q == BitW'(DacBits - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= SpiIdle;
            div_q    <= '0;
            bit_q    <= '0;
            phase_q  <= 1'b0;
            sh_q     <= '0;
            sync_n_q <= 1'b1;
            sclk_q   <= 1'b1;
        end else begin
            unique case (state_q)
                SpiIdle: begin
                    if (start_i) begin
                        sh_q     <= data_i;
                        sync_n_q <= 1'b0;
                        sclk_q   <= 1'b1;
                        div_q    <= '0;
                        bit_q    <= '0;
                        phase_q  <= 1'b0;
                        state_q  <= SpiSync;
                    end
                end
                SpiSync: begin
                    if (last_div) begin
                        div_q   <= '0;
                        state_q <= SpiShift;
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                SpiShift: begin
                    // phase 0 = sclk high half, phase 1 = sclk low half of a bit
                    if (last_div) begin
                        div_q <= '0;
                        if (!phase_q) begin
                            sclk_q  <= 1'b0;
                            phase_q <= 1'b1;
                        end else begin
                            sclk_q  <= 1'b1;
                            phase_q <= 1'b0;
                            if (last_bit) begin
                                state_q <= SpiTail;
                            end else begin
                                bit_q <= bit_q + BitW'(1);
                                sh_q  <= {sh_q[DacBits-2:0], 1'b0};
                            end
                        end
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                SpiTail: begin
                    if (last_div) begin
                        sync_n_q <= 1'b1;
                        sh_q     <= '0;
                        div_q    <= '0;
                        state_q  <= SpiIdle;
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                default: state_q <= SpiIdle;
            endcase
        end
    end

    assign done_o   = (state_q == SpiTail) && last_div;
    assign sync_n_o = sync_n_q;
    assign sclk_o   = sclk_q;
    assign din_o    = sh_q[DacBits-1];

endmodule

// File: rtl/tap_ctl_resp.sv
// TAP command responder: captures the control word on req, rewrites the threshold DAC
// only when the threshold changed, then applies the comparator and trigger bits.
module tap_ctl_resp
    import tap_ctl_resp_pkg::*;
#(
    parameter int unsigned ClkDiv  = 4,
    parameter int unsigned ThrW    = 14,
    parameter int unsigned DacBits = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    input  logic [TapCtlSize-1:0] ctl_i,
    output logic                  busy_o,
    output logic                  cmp_gt_o,
    output logic                  cmp_et_o,
    output logic                  cmp_lt_o,
    output logic                  trig_en_o,
    output logic [ThrW-1:0]       thr_applied_o,
    output logic                  dac_sync_n_o,
    output logic                  dac_sclk_o,
    output logic                  dac_din_o
);

    resp_state_e     state_q;
    tap_ctl_t        ctl_q;
    logic            busy_q;
    logic            cmp_gt_q;
    logic            cmp_et_q;
    logic            cmp_lt_q;
    logic            trig_en_q;
    logic [ThrW-1:0] thr_applied_q;
    logic            thr_valid_q;

    logic            need_write;
    logic            dac_start;
    logic            dac_done;
    logic [ThrW-1:0] thr_cap;

    assign thr_cap    = tap_ctl_thr(ctl_q);
    // An unwritten DAC must be programmed even if the value matches the reset default.
    assign need_write = !thr_valid_q || (thr_cap != thr_applied_q);
    assign dac_start  = (state_q == StLatch) && need_write;

    tap_dac_spi #(
        .ClkDiv  (ClkDiv),
        .DacBits (DacBits)
    ) u_dac_spi (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start_i  (dac_start),
        .data_i   ({{(DacBits - ThrW){1'b0}}, thr_cap}),
        .done_o   (dac_done),
        .sync_n_o (dac_sync_n_o),
        .sclk_o   (dac_sclk_o),
        .din_o    (dac_din_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            ctl_q         <= '0;
            busy_q        <= 1'b0;
            cmp_gt_q      <= 1'b0;
            cmp_et_q      <= 1'b0;
            cmp_lt_q      <= 1'b0;
            trig_en_q     <= 1'b0;
            thr_applied_q <= '0;
            thr_valid_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_i) begin
                        ctl_q   <= ctl_i;
                        busy_q  <= 1'b1;
                        state_q <= StLatch;
                    end
                end
                StLatch: state_q <= need_write ? StDac : StApply;
                StDac: begin
                    if (dac_done) begin
                        thr_applied_q <= thr_cap;
                        thr_valid_q   <= 1'b1;
                        state_q       <= StApply;
                    end
                end
                StApply: begin
                    cmp_gt_q  <= tap_ctl_gt(ctl_q);
                    cmp_et_q  <= tap_ctl_et(ctl_q);
                    cmp_lt_q  <= tap_ctl_lt(ctl_q);
                    trig_en_q <= tap_ctl_trig_en(ctl_q);
                    state_q   <= StDone;
                end
                StDone: begin
                    // A held req must not retrigger; wait for it to drop.
                    busy_q <= 1'b0;
                    if (!req_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign cmp_gt_o      = cmp_gt_q;
    assign cmp_et_o      = cmp_et_q;
    assign cmp_lt_o      = cmp_lt_q;
    assign trig_en_o     = trig_en_q;
    assign thr_applied_o = thr_applied_q;

endmodule

// File: tb/tb_tap_ctl_resp.sv
// Bench for tap_ctl_resp: a ClkDiv=4 and a ClkDiv=1 instance checked every cycle against a
// closed-form timing model, plus literal checks of frames, busy lengths and reset behaviour.
module tb_tap_ctl_resp;
    import tap_ctl_resp_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req        [2];
    logic [17:0] ctl        [2];
    logic        busy       [2];
    logic        gt         [2];
    logic        et         [2];
    logic        lt         [2];
    logic        trig       [2];
    logic [13:0] thr_app    [2];
    logic        sync_n     [2];
    logic        sclk       [2];
    logic        din        [2];

    int n_vec = 0;
    int n_err = 0;

    tap_ctl_resp #(.ClkDiv(4), .ThrW(14), .DacBits(16)) u_dut_div4 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .ctl_i(ctl[0]), .busy_o(busy[0]),
        .cmp_gt_o(gt[0]), .cmp_et_o(et[0]), .cmp_lt_o(lt[0]), .trig_en_o(trig[0]),
        .thr_applied_o(thr_app[0]), .dac_sync_n_o(sync_n[0]), .dac_sclk_o(sclk[0]),
        .dac_din_o(din[0])
    );

    tap_ctl_resp #(.ClkDiv(1), .ThrW(14), .DacBits(16)) u_dut_div1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .ctl_i(ctl[1]), .busy_o(busy[1]),
        .cmp_gt_o(gt[1]), .cmp_et_o(et[1]), .cmp_lt_o(lt[1]), .trig_en_o(trig[1]),
        .thr_applied_o(thr_app[1]), .dac_sync_n_o(sync_n[1]), .dac_sclk_o(sclk[1]),
        .dac_din_o(din[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [17:0] mk(input logic tr, input logic [13:0] th, input logic l,
                                       input logic e, input logic g);
        return {tr, th, l, e, g};
    endfunction

    // Model: mode 0 idle, 1 transaction in flight (n = cycles since acceptance), 2 waiting
    // for req to drop. L = extra DAC cycles, (2 + 2*16) * ClkDiv when a write happens.
    int          m_mode  [2];
    int          m_n     [2];
    int          m_len   [2];
    logic        m_wr    [2];
    logic [13:0] m_thr   [2];
    logic [3:0]  m_cap   [2];
    logic [3:0]  m_app   [2];
    logic [13:0] m_athr  [2];
    logic        m_valid [2];

    function automatic int div_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_mode[i] = 0; m_n[i] = 0; m_len[i] = 0; m_wr[i] = 1'b0;
                m_thr[i] = '0; m_cap[i] = '0; m_app[i] = '0; m_athr[i] = '0;
                m_valid[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_mode[i] == 0) begin
                    if (req[i]) begin
                        m_thr[i]  = ctl[i][16:3];
                        m_cap[i]  = {ctl[i][17], ctl[i][2:0]};
                        m_wr[i]   = !m_valid[i] || (ctl[i][16:3] != m_athr[i]);
                        m_len[i]  = m_wr[i] ? 34 * div_of(i) : 0;
                        m_n[i]    = 0;
                        m_mode[i] = 1;
                    end
                end else if (m_mode[i] == 1) begin
                    m_n[i]++;
                    if (m_wr[i] && m_n[i] == m_len[i] + 1) begin
                        m_athr[i]  = m_thr[i];
                        m_valid[i] = 1'b1;
                    end
                    if (m_n[i] == m_len[i] + 2) m_app[i] = m_cap[i];
                    if (m_n[i] == m_len[i] + 3) m_mode[i] = req[i] ? 2 : 0;
                end else if (!req[i]) begin
                    m_mode[i] = 0;
                end
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                int          d, m, mp;
                logic        e_sync, e_sclk, e_din, din_chk;
                logic [15:0] fr;
                d       = div_of(i);
                fr      = {2'b00, m_thr[i]};
                e_sync  = 1'b1;
                e_sclk  = 1'b1;
                e_din   = 1'b0;
                din_chk = 1'b0;
                if (m_mode[i] == 1 && m_wr[i] && m_n[i] >= 1 && m_n[i] <= m_len[i]) begin
                    e_sync = 1'b0;
                    m      = m_n[i] - 1;
                    if (m < d) begin
                        e_din   = fr[15];
                        din_chk = 1'b1;
                    end else begin
                        mp = m - d;
                        if (mp < 32 * d) begin
                            e_sclk  = (mp % (2 * d)) < d;
                            e_din   = fr[15 - mp / (2 * d)];
                            din_chk = 1'b1;
                        end
                    end
                end
                chk($sformatf("busy%0d", i), 32'(busy[i]), 32'(m_mode[i] == 1));
                chk($sformatf("sync_n%0d", i), 32'(sync_n[i]), 32'(e_sync));
                chk($sformatf("sclk%0d", i), 32'(sclk[i]), 32'(e_sclk));
                if (din_chk) chk($sformatf("din%0d", i), 32'(din[i]), 32'(e_din));
                chk($sformatf("cmp%0d", i), 32'({trig[i], lt[i], et[i], gt[i]}),
                    32'(m_app[i]));
                chk($sformatf("thr_applied%0d", i), 32'(thr_app[i]), 32'(m_athr[i]));
            end
        end
    end

    // Independent observers used by the literal checks.
    int          mon_busy  [2];
    int          mon_fall  [2];
    int          mon_slow  [2];
    logic [15:0] mon_frame [2];
    logic        prev_sclk [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (busy[i]) mon_busy[i]++;
            if (!sync_n[i]) mon_slow[i]++;
            if (prev_sclk[i] && !sclk[i] && !sync_n[i]) begin
                mon_fall[i]++;
                mon_frame[i] = {mon_frame[i][14:0], din[i]};
            end
            prev_sclk[i] = sclk[i];
        end
    end

    task automatic start(input int i, input logic [17:0] c, input logic hold);
        @(posedge clk);
        #2;
        mon_busy[i] = 0; mon_fall[i] = 0; mon_slow[i] = 0; mon_frame[i] = '0;
        ctl[i] = c;
        req[i] = 1'b1;
        @(posedge clk);
        #2;
        if (!hold) req[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int k;
        k = 0;
        while (busy[i] && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (busy[i]) chk("busy_timeout", 32'(busy[i]), 32'd0);
        @(negedge clk);
        #1;
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; ctl[i] = '0; mon_busy[i] = 0; mon_fall[i] = 0;
            mon_slow[i] = 0; mon_frame[i] = '0; prev_sclk[i] = 1'b1;
        end
        #23;
        chk("rst_busy", 32'(busy[0]), 32'd0);
        chk("rst_sync_n", 32'(sync_n[0]), 32'd1);
        chk("rst_sclk", 32'(sclk[0]), 32'd1);
        chk("rst_din", 32'(din[0]), 32'd0);
        chk("rst_thr_applied", 32'(thr_app[0]), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Test 1: first write of 0x0123
        start(0, mk(1'b1, 14'h0123, 1'b0, 1'b0, 1'b1), 1'b0);
        wait_idle(0);
        chk("t1_busy_len", 32'(mon_busy[0]), 32'd139);
        chk("t1_falls", 32'(mon_fall[0]), 32'd16);
        chk("t1_frame", 32'(mon_frame[0]), 32'h0123);
        chk("t1_thr", 32'(thr_app[0]), 32'h0123);
        chk("t1_gt_trig", 32'({trig[0], gt[0]}), 32'b11);

        // Test 2: same threshold, no DAC traffic
        start(0, mk(1'b1, 14'h0123, 1'b0, 1'b1, 1'b1), 1'b0);
        chk("t2_busy_edge0", 32'(busy[0]), 32'd1);
        @(posedge clk);
        #1;
        chk("t2_et_edge1", 32'(et[0]), 32'd0);
        @(posedge clk);
        #1;
        chk("t2_et_edge2", 32'(et[0]), 32'd1);
        wait_idle(0);
        chk("t2_busy_len", 32'(mon_busy[0]), 32'd3);
        chk("t2_sync_low", 32'(mon_slow[0]), 32'd0);

        // Test 3: req held through done
        start(0, mk(1'b0, 14'h0123, 1'b1, 1'b0, 1'b0), 1'b1);
        wait_idle(0);
        repeat (10) @(negedge clk);
        chk("t3_busy_len", 32'(mon_busy[0]), 32'd3);
        chk("t3_sync_low", 32'(mon_slow[0]), 32'd0);
        chk("t3_lt", 32'(lt[0]), 32'd1);
        @(posedge clk);
        #2;
        req[0] = 1'b0;

        // Test 4: ctl glitch mid-transaction is ignored
        start(0, mk(1'b1, 14'h0456, 1'b0, 1'b0, 1'b1), 1'b0);
        repeat (20) @(posedge clk);
        #2;
        ctl[0] = mk(1'b0, 14'h3FFF, 1'b1, 1'b1, 1'b0);
        wait_idle(0);
        chk("t4_frame", 32'(mon_frame[0]), 32'h0456);
        chk("t4_thr", 32'(thr_app[0]), 32'h0456);
        chk("t4_cmp", 32'({trig[0], lt[0], et[0], gt[0]}), 32'b1001);

        // Test 5: async reset mid-frame, then thr=0 must still be written
        start(0, mk(1'b1, 14'h0777, 1'b0, 1'b0, 1'b1), 1'b0);
        k = 0;
        while (mon_fall[0] < 7 && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("t5_reach_bit7", 32'(mon_fall[0]), 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_busy", 32'(busy[0]), 32'd0);
        chk("t5_sync_n", 32'(sync_n[0]), 32'd1);
        chk("t5_sclk", 32'(sclk[0]), 32'd1);
        chk("t5_thr", 32'(thr_app[0]), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        start(0, mk(1'b1, 14'h0000, 1'b0, 1'b0, 1'b1), 1'b0);
        wait_idle(0);
        chk("t5_rewrite_len", 32'(mon_busy[0]), 32'd139);
        chk("t5_rewrite_falls", 32'(mon_fall[0]), 32'd16);
        chk("t5_rewrite_frame", 32'(mon_frame[0]), 32'h0000);

        // Test 6: ClkDiv=1 instance, alternating pattern
        start(1, mk(1'b1, 14'h2AAA, 1'b0, 1'b1, 1'b0), 1'b0);
        wait_idle(1);
        chk("t6_busy_len", 32'(mon_busy[1]), 32'd37);
        chk("t6_falls", 32'(mon_fall[1]), 32'd16);
        chk("t6_frame", 32'(mon_frame[1]), 32'h2AAA);
        chk("t6_thr", 32'(thr_app[1]), 32'h2AAA);
        chk("t6_et", 32'(et[1]), 32'd1);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
